// File: rtl/l2_way_ctrl_if.sv
// Access, flush and writeback signals between the L2 controller and the way-control block.
// The controller drives the master side; l2_way_ctrl takes the slave side.
interface l2_way_ctrl_if #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned TAG_W   = 16 - 4 - INDEX_W
);
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag_in;
    logic               touch;
    logic               load;
    logic               mark_dirty;
    logic               flush_req;
    logic               wb_ack;

    logic               hit_a;
    logic               hit_b;
    logic               hit_c;
    logic               hit_d;
    logic               hit;
    logic [3:0]         victim;
    logic [TAG_W-1:0]   victim_tag;
    logic               victim_dirty;
    logic               wb_req;
    logic [TAG_W-1:0]   wb_tag;
    logic [INDEX_W-1:0] wb_index;
    logic [1:0]         wb_way;
    logic               busy;
    logic               flush_done;

    modport master (
        output index, tag_in, touch, load, mark_dirty, flush_req, wb_ack,
        input  hit_a, hit_b, hit_c, hit_d, hit, victim, victim_tag, victim_dirty,
        input  wb_req, wb_tag, wb_index, wb_way, busy, flush_done
    );

    modport slave (
        input  index, tag_in, touch, load, mark_dirty, flush_req, wb_ack,
        output hit_a, hit_b, hit_c, hit_d, hit, victim, victim_tag, victim_dirty,
        output wb_req, wb_tag, wb_index, wb_way, busy, flush_done
    );
endinterface

// File: rtl/l2_way_ctrl.sv
// 4-way L2 tag/state array with tree pseudo-LRU replacement and a dirty-line flush engine
// that walks every {set, way} slot and hands dirty lines out as writeback requests.
module l2_way_ctrl #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned TAG_W   = 16 - 4 - INDEX_W
) (
    input logic          clk,
    input logic          reset,
    l2_way_ctrl_if.slave bus
);
    localparam int unsigned Sets = 1 << INDEX_W;
    localparam int unsigned PtrW = INDEX_W + 2;

    typedef enum logic [1:0] {StIdle, StScan, StWbWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;

    logic              valid_q [4][Sets];
    logic              dirty_q [4][Sets];
    logic [TAG_W-1:0]  tag_q   [4][Sets];
    logic [2:0]        plru_q  [Sets];

    logic [3:0]        way_match;
    logic [1:0]        hit_way;
    logic [1:0]        vict_way;
    logic [2:0]        plru_cur;
    logic              in_flush;
    logic              clr_dirty;
    logic              do_load;
    logic              do_touch;
    logic              do_dirty;
    logic [INDEX_W-1:0] ptr_set;
    logic [1:0]        ptr_way;
    logic              slot_dirty;
    logic              last_slot;

    // Point the tree away from the accessed way: bit0 picks the other half, bit1/bit2 the sibling.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] way);
        logic [2:0] n;
        n    = p;
        n[0] = ~way[1];
        if (way[1]) begin
            n[2] = ~way[0];
        end else begin
            n[1] = ~way[0];
        end
        return n;
    endfunction

    assign in_flush   = (state_q != StIdle);
    assign ptr_set    = ptr_q[PtrW-1:2];
    assign ptr_way    = ptr_q[1:0];
    assign slot_dirty = valid_q[ptr_way][ptr_set] && dirty_q[ptr_way][ptr_set];
    assign last_slot  = &ptr_q;

    always_comb begin
        way_match = '0;
        for (int w = 0; w < 4; w++) begin
            way_match[w] = valid_q[w][bus.index] && (tag_q[w][bus.index] == bus.tag_in) &&
                           !in_flush;
        end
    end

    always_comb begin
        hit_way = 2'd3;
        if (way_match[0]) begin
            hit_way = 2'd0;
        end else if (way_match[1]) begin
            hit_way = 2'd1;
        end else if (way_match[2]) begin
            hit_way = 2'd2;
        end
    end

    // Fill invalid ways in order a..d before consulting the PLRU tree.
    always_comb begin
        plru_cur = plru_q[bus.index];
        vict_way = 2'd0;
        if (!valid_q[0][bus.index]) begin
            vict_way = 2'd0;
        end else if (!valid_q[1][bus.index]) begin
            vict_way = 2'd1;
        end else if (!valid_q[2][bus.index]) begin
            vict_way = 2'd2;
        end else if (!valid_q[3][bus.index]) begin
            vict_way = 2'd3;
        end else if (!plru_cur[0]) begin
            vict_way = {1'b0, plru_cur[1]};
        end else begin
            vict_way = {1'b1, plru_cur[2]};
        end
    end

    assign bus.hit_a        = way_match[0];
    assign bus.hit_b        = way_match[1];
    assign bus.hit_c        = way_match[2];
    assign bus.hit_d        = way_match[3];
    assign bus.hit          = |way_match;
    assign bus.victim       = 4'b0001 << vict_way;
    assign bus.victim_tag   = tag_q[vict_way][bus.index];
    assign bus.victim_dirty = dirty_q[vict_way][bus.index];
    assign bus.wb_tag       = tag_q[ptr_way][ptr_set];
    assign bus.wb_index     = ptr_set;
    assign bus.wb_way       = ptr_way;

    // Load owns the set this cycle, so a concurrent touch or mark_dirty is dropped.
    assign do_load  = bus.load && !in_flush;
    assign do_touch = bus.touch && bus.hit && !bus.load;
    assign do_dirty = bus.mark_dirty && bus.hit && !bus.load;

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        clr_dirty       = 1'b0;
        bus.wb_req      = 1'b0;
        bus.busy        = 1'b1;
        bus.flush_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.busy = 1'b0;
                if (bus.flush_req) begin
                    state_d = StScan;
                    ptr_d   = '0;
                end
            end
            StScan: begin
                if (slot_dirty) begin
                    state_d = StWbWait;
                end else begin
                    ptr_d = ptr_q + PtrW'(1);
                    if (last_slot) begin
                        state_d = StDone;
                    end
                end
            end
            StWbWait: begin
                bus.wb_req = 1'b1;
                if (bus.wb_ack) begin
                    clr_dirty = 1'b1;
                    ptr_d     = ptr_q + PtrW'(1);
                    state_d   = last_slot ? StDone : StScan;
                end
            end
            StDone: begin
                bus.flush_done = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < Sets; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < 4; w++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    tag_q[w][s]   <= '0;
                end
            end
        end else begin
            if (do_load) begin
                tag_q[vict_way][bus.index]   <= bus.tag_in;
                valid_q[vict_way][bus.index] <= 1'b1;
                dirty_q[vict_way][bus.index] <= 1'b0;
                plru_q[bus.index]            <= plru_touch(plru_cur, vict_way);
            end else begin
                if (do_touch) begin
                    plru_q[bus.index] <= plru_touch(plru_cur, hit_way);
                end
                if (do_dirty) begin
                    dirty_q[hit_way][bus.index] <= 1'b1;
                end
            end
            if (clr_dirty) begin
                dirty_q[ptr_way][ptr_set] <= 1'b0;
            end
        end
    end
endmodule
